// File: rtl/bisr_pkg.sv
// ============================================================
// bisr_pkg : shared state encodings and width helper for BISR blocks
// Revision 1.0
// ============================================================
`default_nettype none

package bisr_pkg;

  localparam logic [1:0] c_ST_IDLE   = 2'd0;
  localparam logic [1:0] c_ST_ALLOC  = 2'd1;
  localparam logic [1:0] c_ST_ACTIVE = 2'd2;

  // Index width that never collapses to zero for degenerate sizes.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

`default_nettype wire

// File: rtl/priority_encoder.sv
// ============================================================
// priority_encoder : lowest-index set bit of req
// Revision 1.0
// ============================================================
`default_nettype none

module priority_encoder #(
  parameter int WIDTH = 2,
  parameter int IDX_W = 1
) (
  input  logic [WIDTH-1:0] req,
  output logic             valid,
  output logic [IDX_W-1:0] idx
);

  always_comb begin
    valid = 1'b0;
    idx   = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (req[i]) begin
        valid = 1'b1;
        idx   = IDX_W'(i);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/rr_picker.sv
// ============================================================
// rr_picker : first set req bit at or above ptr, wrapping modulo COLS
// Revision 1.0
// ============================================================
`default_nettype none

module rr_picker #(
  parameter int COLS  = 4,
  parameter int COL_W = 2
) (
  input  logic [COLS-1:0]  req,
  input  logic [COL_W-1:0] ptr,
  output logic             valid,
  output logic [COL_W-1:0] idx
);

  logic [COL_W-1:0] w_c;

  // Scan offsets from farthest to nearest so the nearest hit wins.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    w_c   = '0;
    for (int i = COLS - 1; i >= 0; i--) begin
      w_c = COL_W'((int'(ptr) + i) % COLS);
      if (req[w_c]) begin
        valid = 1'b1;
        idx   = w_c;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/proxy_pool_arbiter.sv
// ============================================================
// proxy_pool_arbiter : assigns shared proxy PEs to faulty array columns
// Revision 1.0
// ============================================================
`default_nettype none

module proxy_pool_arbiter
  import bisr_pkg::*;
#(
  parameter  int COLS      = 4,
  parameter  int NUM_PROXY = 2,
  localparam int COL_W     = clog2_min1(COLS),
  localparam int PRX_W     = clog2_min1(NUM_PROXY)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       stw_complete,
  input  logic [COLS-1:0]            col_fault,
  input  logic                       weight_reload,
  output logic [COLS-1:0]            grant_valid,
  output logic [COLS*PRX_W-1:0]      grant_proxy_idx,
  output logic [NUM_PROXY-1:0]       proxy_busy,
  output logic [NUM_PROXY*COL_W-1:0] proxy_col,
  output logic [NUM_PROXY-1:0]       load_proxy,
  output logic [NUM_PROXY-1:0]       proxy_matmul,
  output logic                       alloc_done,
  output logic                       overflow,
  output logic [COLS-1:0]            unserved
);

  logic [1:0]           r_state;
  logic [COLS-1:0]      r_pending;
  logic [COL_W-1:0]     r_rr_ptr;

  logic [NUM_PROXY-1:0] w_free;
  logic                 w_free_valid;
  logic [PRX_W-1:0]     w_free_idx;
  logic                 w_pick_valid;
  logic [COL_W-1:0]     w_pick_idx;

  assign w_free     = ~proxy_busy;
  assign alloc_done = (r_state == c_ST_ACTIVE);

  priority_encoder #(
    .WIDTH (NUM_PROXY),
    .IDX_W (PRX_W)
  ) u_free_enc (
    .req   (w_free),
    .valid (w_free_valid),
    .idx   (w_free_idx)
  );

  rr_picker #(
    .COLS  (COLS),
    .COL_W (COL_W)
  ) u_col_pick (
    .req   (r_pending),
    .ptr   (r_rr_ptr),
    .valid (w_pick_valid),
    .idx   (w_pick_idx)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state         <= c_ST_IDLE;
      r_pending       <= '0;
      r_rr_ptr        <= '0;
      grant_valid     <= '0;
      grant_proxy_idx <= '0;
      proxy_busy      <= '0;
      proxy_col       <= '0;
      load_proxy      <= '0;
      proxy_matmul    <= '0;
      overflow        <= 1'b0;
      unserved        <= '0;
    end else begin
      load_proxy <= '0;
      // Reload wins over everything else; rr pointer is deliberately kept.
      if (weight_reload) begin
        r_state         <= c_ST_IDLE;
        r_pending       <= '0;
        grant_valid     <= '0;
        grant_proxy_idx <= '0;
        proxy_busy      <= '0;
        proxy_col       <= '0;
        proxy_matmul    <= '0;
        overflow        <= 1'b0;
        unserved        <= '0;
      end else begin
        proxy_matmul <= proxy_matmul | load_proxy;
        case (r_state)
          c_ST_IDLE: begin
            if (stw_complete) begin
              r_pending <= col_fault;
              r_state   <= c_ST_ALLOC;
            end
          end
          c_ST_ALLOC: begin
            if (!w_pick_valid) begin
              overflow <= 1'b0;
              unserved <= '0;
              r_state  <= c_ST_ACTIVE;
            end else if (w_free_valid) begin
              grant_valid[w_pick_idx]                          <= 1'b1;
              grant_proxy_idx[int'(w_pick_idx)*PRX_W +: PRX_W] <= w_free_idx;
              proxy_busy[w_free_idx]                           <= 1'b1;
              proxy_col[int'(w_free_idx)*COL_W +: COL_W]       <= w_pick_idx;
              load_proxy[w_free_idx]                           <= 1'b1;
              r_pending[w_pick_idx]                            <= 1'b0;
              r_rr_ptr <= (int'(w_pick_idx) == COLS - 1) ? '0 : w_pick_idx + 1'b1;
            end else begin
              overflow  <= 1'b1;
              unserved  <= r_pending;
              r_pending <= '0;
              r_state   <= c_ST_ACTIVE;
            end
          end
          c_ST_ACTIVE: ;
          default: r_state <= c_ST_IDLE;
        endcase
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_proxy_pool_arbiter.sv
// ============================================================
// tb_proxy_pool_arbiter : table-driven scoreboard bench, COLS=4 NUM_PROXY=2
// Revision 1.0
// ============================================================
`default_nettype none

module tb_proxy_pool_arbiter;

  typedef struct {
    string      name;
    logic       stw;
    logic [3:0] fault;
    logic       reload;
    logic [3:0] gv;
    logic [3:0] gpi;
    logic [1:0] busy;
    logic [3:0] pcol;
    logic [1:0] load;
    logic [1:0] mm;
    logic       ovf;
    logic [3:0] uns;
    logic       done;
  } vec_t;

  logic       clk;
  logic       rst;
  logic       r_stw;
  logic [3:0] r_fault;
  logic       r_reload;
  logic [3:0] w_gv;
  logic [3:0] w_gpi;
  logic [1:0] w_busy;
  logic [3:0] w_pcol;
  logic [1:0] w_load;
  logic [1:0] w_mm;
  logic       w_done;
  logic       w_ovf;
  logic [3:0] w_uns;

  int   r_checks;
  int   r_errors;
  vec_t r_tbl[$];
  vec_t r_exp_q[$];

  proxy_pool_arbiter #(
    .COLS      (4),
    .NUM_PROXY (2)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .stw_complete    (r_stw),
    .col_fault       (r_fault),
    .weight_reload   (r_reload),
    .grant_valid     (w_gv),
    .grant_proxy_idx (w_gpi),
    .proxy_busy      (w_busy),
    .proxy_col       (w_pcol),
    .load_proxy      (w_load),
    .proxy_matmul    (w_mm),
    .alloc_done      (w_done),
    .overflow        (w_ovf),
    .unserved        (w_uns)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    r_checks++;
    if (act !== exp) begin
      r_errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, ".gv"},   32'(w_gv),   32'h0);
    chk({nm, ".gpi"},  32'(w_gpi),  32'h0);
    chk({nm, ".busy"}, 32'(w_busy), 32'h0);
    chk({nm, ".pcol"}, 32'(w_pcol), 32'h0);
    chk({nm, ".load"}, 32'(w_load), 32'h0);
    chk({nm, ".mm"},   32'(w_mm),   32'h0);
    chk({nm, ".done"}, 32'(w_done), 32'h0);
    chk({nm, ".ovf"},  32'(w_ovf),  32'h0);
    chk({nm, ".uns"},  32'(w_uns),  32'h0);
  endtask

  task automatic add(input string nm, input logic stw, input logic [3:0] fault,
                     input logic reload, input logic [3:0] gv, input logic [3:0] gpi,
                     input logic [1:0] busy, input logic [3:0] pcol, input logic [1:0] load,
                     input logic [1:0] mm, input logic ovf, input logic [3:0] uns,
                     input logic done);
    vec_t v;
    v.name = nm; v.stw = stw; v.fault = fault; v.reload = reload;
    v.gv = gv; v.gpi = gpi; v.busy = busy; v.pcol = pcol; v.load = load;
    v.mm = mm; v.ovf = ovf; v.uns = uns; v.done = done;
    r_tbl.push_back(v);
  endtask

  task automatic check_pop();
    vec_t e;
    if (r_exp_q.size() == 0) begin
      chk("scoreboard_empty", 32'h1, 32'h0);
    end else begin
      e = r_exp_q.pop_front();
      chk({e.name, ".gv"},   32'(w_gv),   32'(e.gv));
      chk({e.name, ".gpi"},  32'(w_gpi),  32'(e.gpi));
      chk({e.name, ".busy"}, 32'(w_busy), 32'(e.busy));
      chk({e.name, ".pcol"}, 32'(w_pcol), 32'(e.pcol));
      chk({e.name, ".load"}, 32'(w_load), 32'(e.load));
      chk({e.name, ".mm"},   32'(w_mm),   32'(e.mm));
      chk({e.name, ".ovf"},  32'(w_ovf),  32'(e.ovf));
      chk({e.name, ".uns"},  32'(w_uns),  32'(e.uns));
      chk({e.name, ".done"}, 32'(w_done), 32'(e.done));
    end
  endtask

  // Drive one row for one edge, queue its expectation, check just after the edge.
  task automatic run_rows(input int first, input int last);
    for (int i = first; i <= last; i++) begin
      r_stw    = r_tbl[i].stw;
      r_fault  = r_tbl[i].fault;
      r_reload = r_tbl[i].reload;
      r_exp_q.push_back(r_tbl[i]);
      @(posedge clk);
      #1;
      r_stw    = 1'b0;
      r_fault  = 4'b0000;
      r_reload = 1'b0;
      check_pop();
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk_zero("reset_async");
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    r_checks = 0;
    r_errors = 0;
    rst      = 1'b1;
    r_stw    = 1'b0;
    r_fault  = 4'b0000;
    r_reload = 1'b0;

    //   name             stw fault    rel gv       gpi      busy   pcol     load   mm     ovf uns      done
    add("a_stw",          1, 4'b0000, 0, 4'b0000, 4'b0000, 2'b00, 4'b0000, 2'b00, 2'b00, 0, 4'b0000, 0); // 0
    add("a_active",       0, 4'b0000, 0, 4'b0000, 4'b0000, 2'b00, 4'b0000, 2'b00, 2'b00, 0, 4'b0000, 1);
    add("a_hold",         0, 4'b0000, 0, 4'b0000, 4'b0000, 2'b00, 4'b0000, 2'b00, 2'b00, 0, 4'b0000, 1);
    add("a_reload",       0, 4'b0000, 1, 4'b0000, 4'b0000, 2'b00, 4'b0000, 2'b00, 2'b00, 0, 4'b0000, 0);
    add("b_stw",          1, 4'b0101, 0, 4'b0000, 4'b0000, 2'b00, 4'b0000, 2'b00, 2'b00, 0, 4'b0000, 0);
    add("b_g0",           0, 4'b0000, 0, 4'b0001, 4'b0000, 2'b01, 4'b0000, 2'b01, 2'b00, 0, 4'b0000, 0);
    add("b_g1",           0, 4'b0000, 0, 4'b0101, 4'b0100, 2'b11, 4'b1000, 2'b10, 2'b01, 0, 4'b0000, 0);
    add("b_active",       0, 4'b0000, 0, 4'b0101, 4'b0100, 2'b11, 4'b1000, 2'b00, 2'b11, 0, 4'b0000, 1);
    add("f_stw_active",   1, 4'b1111, 0, 4'b0101, 4'b0100, 2'b11, 4'b1000, 2'b00, 2'b11, 0, 4'b0000, 1);
    add("f_hold",         0, 4'b0000, 0, 4'b0101, 4'b0100, 2'b11, 4'b1000, 2'b00, 2'b11, 0, 4'b0000, 1);
    add("d_reload_stw",   1, 4'b1111, 1, 4'b0000, 4'b0000, 2'b00, 4'b0000, 2'b00, 2'b00, 0, 4'b0000, 0); // 10
    add("d_idle",         0, 4'b0000, 0, 4'b0000, 4'b0000, 2'b00, 4'b0000, 2'b00, 2'b00, 0, 4'b0000, 0);
    add("rr3_stw",        1, 4'b1111, 0, 4'b0000, 4'b0000, 2'b00, 4'b0000, 2'b00, 2'b00, 0, 4'b0000, 0);
    add("rr3_g0",         0, 4'b0000, 0, 4'b1000, 4'b0000, 2'b01, 4'b0011, 2'b01, 2'b00, 0, 4'b0000, 0);
    add("rr3_g1",         0, 4'b0000, 0, 4'b1001, 4'b0001, 2'b11, 4'b0011, 2'b10, 2'b01, 0, 4'b0000, 0);
    add("rr3_ovf",        0, 4'b0000, 0, 4'b1001, 4'b0001, 2'b11, 4'b0011, 2'b00, 2'b11, 1, 4'b0110, 1); // 15
    add("c_stw",          1, 4'b1111, 0, 4'b0000, 4'b0000, 2'b00, 4'b0000, 2'b00, 2'b00, 0, 4'b0000, 0); // 16
    add("c_g0",           0, 4'b0000, 0, 4'b0001, 4'b0000, 2'b01, 4'b0000, 2'b01, 2'b00, 0, 4'b0000, 0);
    add("c_g1",           0, 4'b0000, 0, 4'b0011, 4'b0010, 2'b11, 4'b0100, 2'b10, 2'b01, 0, 4'b0000, 0);
    add("c_ovf",          0, 4'b0000, 0, 4'b0011, 4'b0010, 2'b11, 4'b0100, 2'b00, 2'b11, 1, 4'b1100, 1);
    add("c_reload",       0, 4'b0000, 1, 4'b0000, 4'b0000, 2'b00, 4'b0000, 2'b00, 2'b00, 0, 4'b0000, 0); // 20
    add("c2_stw",         1, 4'b1111, 0, 4'b0000, 4'b0000, 2'b00, 4'b0000, 2'b00, 2'b00, 0, 4'b0000, 0);
    add("c2_g0",          0, 4'b0000, 0, 4'b0100, 4'b0000, 2'b01, 4'b0010, 2'b01, 2'b00, 0, 4'b0000, 0);
    add("c2_g1",          0, 4'b0000, 0, 4'b1100, 4'b1000, 2'b11, 4'b1110, 2'b10, 2'b01, 0, 4'b0000, 0);
    add("c2_ovf",         0, 4'b0000, 0, 4'b1100, 4'b1000, 2'b11, 4'b1110, 2'b00, 2'b11, 1, 4'b0011, 1);
    add("c2_reload",      0, 4'b0000, 1, 4'b0000, 4'b0000, 2'b00, 4'b0000, 2'b00, 2'b00, 0, 4'b0000, 0); // 25
    add("e_stw",          1, 4'b0011, 0, 4'b0000, 4'b0000, 2'b00, 4'b0000, 2'b00, 2'b00, 0, 4'b0000, 0); // 26
    add("e_g0",           0, 4'b0000, 0, 4'b0001, 4'b0000, 2'b01, 4'b0000, 2'b01, 2'b00, 0, 4'b0000, 0); // 27
    add("e_quiet0",       0, 4'b0000, 0, 4'b0000, 4'b0000, 2'b00, 4'b0000, 2'b00, 2'b00, 0, 4'b0000, 0); // 28
    add("e_quiet1",       0, 4'b0000, 0, 4'b0000, 4'b0000, 2'b00, 4'b0000, 2'b00, 2'b00, 0, 4'b0000, 0);
    add("e_quiet2",       0, 4'b0000, 0, 4'b0000, 4'b0000, 2'b00, 4'b0000, 2'b00, 2'b00, 0, 4'b0000, 0);
    add("e_restw",        1, 4'b0011, 0, 4'b0000, 4'b0000, 2'b00, 4'b0000, 2'b00, 2'b00, 0, 4'b0000, 0);
    add("e_re_g0",        0, 4'b0000, 0, 4'b0001, 4'b0000, 2'b01, 4'b0000, 2'b01, 2'b00, 0, 4'b0000, 0);
    add("e_re_g1",        0, 4'b0000, 0, 4'b0011, 4'b0010, 2'b11, 4'b0100, 2'b10, 2'b01, 0, 4'b0000, 0);
    add("e_re_active",    0, 4'b0000, 0, 4'b0011, 4'b0010, 2'b11, 4'b0100, 2'b00, 2'b11, 0, 4'b0000, 1); // 34

    #1;
    chk_zero("reset_state");
    @(negedge clk);
    rst = 1'b0;

    run_rows(0, 15);

    // Reset returns rr pointer to column 0 for the overflow scenario.
    @(negedge clk);
    do_reset();
    run_rows(16, 27);

    // Reset asserted between the two grants must clear outputs without a clock edge.
    #2;
    rst = 1'b1;
    #1;
    chk_zero("e_rst_mid_alloc");
    @(posedge clk);
    #1;
    chk_zero("e_rst_held");
    @(negedge clk);
    rst = 1'b0;
    run_rows(28, 34);

    chk("scoreboard_drained", 32'(r_exp_q.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", r_checks, r_errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

endmodule

`default_nettype wire
